fft_io_ctrl: RTL
================

# fft_io_ctrl

Host-side frame sequencer for the 2048-point FFT core. It accepts a stream of real 16-bit samples and writes them into the core's four RAM banks through the host write ports. It then launches the transform, waits for completion, and streams the 17-bit real results back out in natural storage order with valid/ready backpressure. It sits between the sample source/sink and `fft_top`, driving `fft_top`'s iSTART, iDATA, iADDR_RD_x, iADDR_WR_x and iWE_x, and observing its oRDY and oDATA_RE_x.

## Interface
- ADDR_W, 9, bank address width; frame length N = 4·2^ADDR_W (2048)
- TIMEOUT, 65535, max cycles in WAIT before error (only with FFT_IO_TIMEOUT_EN)

- iCLK  in  1  clock
- iRESET  in  1  asynchronous, active-high reset
- iABORT  in  1  synchronous abort, returns to LOAD
- iVALID / iDATA  in  1 / 16  input sample stream
- oREADY  out  1  sample accepted when iVALID & oREADY
- oVALID / oDATA / oLAST  out  1 / 17 / 1  result stream; oLAST on word N-1
- iREADY  in  1  result sink ready
- oSTART  out  1  one-cycle pulse to fft_top iSTART
- iRDY  in  1  fft_top oRDY
- oFFT_DATA  out  16  to fft_top iDATA
- oADDR_WR_0..oADDR_WR_3  out  ADDR_W each  bank write addresses
- oWE_0..oWE_3  out  1 each  bank write enables, one-hot or zero
- oADDR_RD_0..oADDR_RD_3  out  ADDR_W each  bank read addresses (always equal)
- iFFT_RE_0..iFFT_RE_3  in  17 each  fft_top oDATA_RE_x
- oBUSY  out  1  high in every state except LOAD
- oERR  out  1  WAIT timeout flag

## Operation
- States: LOAD → FLUSH → START → WAIT → RD_ADDR → RD_WAIT → RD_CAP → OUT → (RD_ADDR or LOAD); ERR only with macro.
- Reset and iABORT: state LOAD, sample counter k = 0, read address a = 0. Reset values: oREADY=1; all other outputs 0.
- LOAD: oREADY=1. Each accepted sample k drives, on the next cycle:
  - bank b = k[1:0] and address k[ADDR_W+1:2];
  - oWE_b=1 for that cycle only, oADDR_WR_b = address, oFFT_DATA = sample.
  - Then k increments.
  - When sample N-1 is accepted, go to FLUSH (oREADY=0).
- FLUSH: the last write strobe is issued.
- START: oSTART=1 for exactly one cycle.
- WAIT: complete on a rising edge of iRDY (iRDY=1 while the registered previous iRDY was 0, both observed in WAIT). A level already high on entry does not count.
- Readout, per group a:
  - RD_ADDR: oADDR_RD_0..3 = a.
  - RD_WAIT: RAM latency cycle.
  - RD_CAP: capture iFFT_RE_0..3 into a 4×17 buffer, exactly 2 edges after the address update.
  - OUT: present buffer words 0..3 in order. Word j = 4a + bank.
- OUT handshake: oVALID=1. oDATA and oLAST are held stable while iREADY=0, and the word advances on oVALID & iREADY.
- After word 3 of group a is accepted: if a < 2^ADDR_W-1, increment a and go to RD_ADDR; otherwise go to LOAD, with k = 0.
- oLAST=1 only on output word N-1.
- iABORT wins over a simultaneous handshake: the sample is dropped and no oWE is issued, or the output word is discarded. oVALID, oSTART and oERR are 0 on the next cycle.
- Counters wrap only via the state transitions above. k never exceeds N-1.

## Timing
- Input throughput: 1 sample/cycle. Accept at edge t → oWE at cycle t+1.
- Last accept at edge t: FLUSH at t+1, oSTART at t+2, WAIT from t+3.
- Output group: 3 overhead cycles plus 4 handshakes. Best case is 4 words per 7 cycles.
- iRDY edge detected at edge e → RD_ADDR at e+1 → first oVALID at e+4.
- All outputs are registered or decoded directly from state registers. There is no combinational input→output path except oVALID/oDATA being independent of iREADY.

## Configuration
- FFT_IO_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT without an iRDY edge, go to ERR with oERR=1 and oBUSY=1.
  - ERR is left only by iABORT or iRESET.
- Undefined: no counter, oERR tied 0, WAIT is unbounded.

## Test plan
- Ramp load 0..2047 with iVALID held high → sample 5 produces oWE_1=1 with oADDR_WR_1=1 and oFFT_DATA=5; sample 2047 produces oWE_3 with address 511; oSTART is a single pulse 2 cycles after the last accept.
- Bank model returning 4·addr+bank after 2-edge latency, iRDY edge, iREADY=1 → oDATA sequence 0..2047 with no gaps or repeats, oLAST only on 2047, oBUSY=0 afterward.
- Readout with iREADY pattern 1,0,1,0… → identical sequence; oDATA is stable in every cycle where oVALID=1 and iREADY=0.
- iRDY held high from reset through oSTART → no readout. Drop iRDY for 1 cycle and raise it → first oVALID 4 cycles after the edge.
- iABORT at sample 100 coincident with iVALID → no oWE for that sample; the next accepted sample writes oWE_0, oADDR_WR_0=0.
- Timeout: with FFT_IO_TIMEOUT_EN and TIMEOUT=16, no iRDY edge → oERR=1 after 16 WAIT cycles and stays set until iABORT. Without the macro → oERR=0 and the block remains in WAIT.

Source files
------------

// File: rtl/fft_io_ctrl.sv
// Host-side frame sequencer for the 2048-point FFT core: loads samples into four RAM banks,
// launches the transform, then streams results out. Optional WAIT timeout: FFT_IO_TIMEOUT_EN.
module fft_io_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 65535
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iABORT,
  input  logic              iVALID,
  input  logic [15:0]       iDATA,
  output logic              oREADY,
  output logic              oVALID,
  output logic [16:0]       oDATA,
  output logic              oLAST,
  input  logic              iREADY,
  output logic              oSTART,
  input  logic              iRDY,
  output logic [15:0]       oFFT_DATA,
  output logic [ADDR_W-1:0] oADDR_WR_0,
  output logic [ADDR_W-1:0] oADDR_WR_1,
  output logic [ADDR_W-1:0] oADDR_WR_2,
  output logic [ADDR_W-1:0] oADDR_WR_3,
  output logic              oWE_0,
  output logic              oWE_1,
  output logic              oWE_2,
  output logic              oWE_3,
  output logic [ADDR_W-1:0] oADDR_RD_0,
  output logic [ADDR_W-1:0] oADDR_RD_1,
  output logic [ADDR_W-1:0] oADDR_RD_2,
  output logic [ADDR_W-1:0] oADDR_RD_3,
  input  logic [16:0]       iFFT_RE_0,
  input  logic [16:0]       iFFT_RE_1,
  input  logic [16:0]       iFFT_RE_2,
  input  logic [16:0]       iFFT_RE_3,
  output logic              oBUSY,
  output logic              oERR,
  output logic [3:0]        oDBG_STATE
);

  typedef enum logic [3:0] {
    ST_LOAD    = 4'd0,
    ST_FLUSH   = 4'd1,
    ST_START   = 4'd2,
    ST_WAIT    = 4'd3,
    ST_RD_ADDR = 4'd4,
    ST_RD_WAIT = 4'd5,
    ST_RD_CAP  = 4'd6,
    ST_OUT     = 4'd7,
    ST_ERR     = 4'd8
  } state_t;

  localparam logic [ADDR_W+1:0] K_LAST = '1;
  localparam logic [ADDR_W-1:0] A_LAST = '1;

  state_t            state_q;
  logic [ADDR_W+1:0] k_q;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [1:0]        j_q;
  logic [3:0]        we_q;
  logic [ADDR_W-1:0] wr_addr_q [4];
  logic [15:0]       fft_data_q;
  logic [16:0]       cap_q [4];
  logic              rdy_prev_q;
  logic              rdy_rise;

`ifdef FFT_IO_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_q;
`else
  logic [15:0] timeout_unused;
  assign timeout_unused = 16'(TIMEOUT);
`endif

  // Only a low-to-high transition of iRDY completes the transform; a level already high does not.
  assign rdy_rise = iRDY & ~rdy_prev_q;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q    <= ST_LOAD;
      k_q        <= '0;
      a_q        <= '0;
      rd_addr_q  <= '0;
      j_q        <= '0;
      we_q       <= '0;
      fft_data_q <= '0;
      rdy_prev_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        wr_addr_q[i] <= '0;
        cap_q[i]     <= '0;
      end
`ifdef FFT_IO_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      we_q       <= '0;
      rdy_prev_q <= iRDY;
      if (iABORT) begin
        state_q   <= ST_LOAD;
        k_q       <= '0;
        a_q       <= '0;
        rd_addr_q <= '0;
        j_q       <= '0;
      end else begin
        case (state_q)
          ST_LOAD: if (iVALID) begin
            we_q[k_q[1:0]]      <= 1'b1;
            wr_addr_q[k_q[1:0]] <= k_q[ADDR_W+1:2];
            fft_data_q          <= iDATA;
            if (k_q == K_LAST) begin
              k_q     <= '0;
              state_q <= ST_FLUSH;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
          ST_FLUSH: state_q <= ST_START;
          ST_START: begin
            state_q <= ST_WAIT;
`ifdef FFT_IO_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
          ST_WAIT: begin
            if (rdy_rise) state_q <= ST_RD_ADDR;
`ifdef FFT_IO_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) state_q <= ST_ERR;
            else tmo_q <= tmo_q + 1'b1;
`endif
          end
          // The address leaves here; one-cycle RAM latency puts the data in place for RD_CAP.
          ST_RD_ADDR: begin
            rd_addr_q <= a_q;
            state_q   <= ST_RD_WAIT;
          end
          ST_RD_WAIT: state_q <= ST_RD_CAP;
          ST_RD_CAP: begin
            cap_q[0] <= iFFT_RE_0;
            cap_q[1] <= iFFT_RE_1;
            cap_q[2] <= iFFT_RE_2;
            cap_q[3] <= iFFT_RE_3;
            j_q      <= '0;
            state_q  <= ST_OUT;
          end
          ST_OUT: if (iREADY) begin
            if (j_q == 2'd3) begin
              j_q <= '0;
              if (a_q == A_LAST) begin
                a_q     <= '0;
                k_q     <= '0;
                state_q <= ST_LOAD;
              end else begin
                a_q     <= a_q + 1'b1;
                state_q <= ST_RD_ADDR;
              end
            end else begin
              j_q <= j_q + 2'd1;
            end
          end
`ifdef FFT_IO_TIMEOUT_EN
          ST_ERR: state_q <= ST_ERR;
`endif
          default: state_q <= ST_LOAD;
        endcase
      end
    end
  end

  // valid/ready: a sample moves on iVALID & oREADY, a result word on oVALID & iREADY;
  // oVALID and oDATA are decoded from registers and never depend on iREADY.
  assign oREADY     = (state_q == ST_LOAD);
  assign oBUSY      = (state_q != ST_LOAD);
  assign oSTART     = (state_q == ST_START);
  assign oVALID     = (state_q == ST_OUT);
  assign oDATA      = cap_q[j_q];
  assign oLAST      = oVALID && (a_q == A_LAST) && (j_q == 2'd3);
  assign oFFT_DATA  = fft_data_q;
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oADDR_WR_0 = wr_addr_q[0];
  assign oADDR_WR_1 = wr_addr_q[1];
  assign oADDR_WR_2 = wr_addr_q[2];
  assign oADDR_WR_3 = wr_addr_q[3];
  assign oADDR_RD_0 = rd_addr_q;
  assign oADDR_RD_1 = rd_addr_q;
  assign oADDR_RD_2 = rd_addr_q;
  assign oADDR_RD_3 = rd_addr_q;
  assign oDBG_STATE = state_q;
`ifdef FFT_IO_TIMEOUT_EN
  assign oERR       = (state_q == ST_ERR);
`else
  assign oERR       = 1'b0;
`endif

endmodule
